// File: rtl/irq_trap_ctrl.sv
// Interrupt entry sequencer: samples/masks M-mode interrupt lines, drains the pipeline, issues one trap commit.
// Optional macro IRQ_SYNC_EN adds a SYNC_STAGES-deep synchronizer ahead of the mip_o register.
module irq_trap_ctrl #(
  parameter int DRAIN_MAX   = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        xint_meip_i,
  input  logic        xint_mtip_i,
  input  logic        xint_msip_i,
  input  logic        mstatus_mie_i,
  input  logic        mie_meie_i,
  input  logic        mie_mtie_i,
  input  logic        mie_msie_i,
  input  logic        wb_exc_i,
  input  logic        drain_done_i,
  input  logic [31:0] resume_pc_i,
  output logic [2:0]  mip_o,
  output logic        irq_req_o,
  output logic        trap_we_o,
  output logic [31:0] trap_cause_o,
  output logic [31:0] trap_epc_o,
  output logic        flush_o,
  output logic        drain_timeout_o,
  output logic [1:0]  state_o
);

  localparam int CW = $clog2(DRAIN_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2,
    RESUME = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    code, code_nxt;
  logic [2:0]    src, src_nxt;
  logic [31:0]   epc, epc_nxt;
  logic          timeout_q, timeout_nxt;
  logic [2:0]    raw;
  logic [2:0]    pend;
  logic [2:0]    win;
  logic [3:0]    win_code;

  assign raw = {xint_meip_i, xint_mtip_i, xint_msip_i};

`ifdef IRQ_SYNC_EN
  logic [2:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      mip_o <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      mip_o <= sync_q[SYNC_STAGES-1];
    end
  end
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mip_o <= '0;
    else       mip_o <= raw;
  end
`endif

  assign pend = mip_o & {mie_meie_i, mie_mtie_i, mie_msie_i} & {3{mstatus_mie_i}};

  // Priority is MEI > MSI > MTI, which is not the bit order of mip.
  always_comb begin
    win      = 3'b000;
    win_code = 4'd0;
    if (pend[2]) begin
      win      = 3'b100;
      win_code = 4'd11;
    end else if (pend[0]) begin
      win      = 3'b001;
      win_code = 4'd3;
    end else if (pend[1]) begin
      win      = 3'b010;
      win_code = 4'd7;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      code      <= '0;
      src       <= '0;
      epc       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      code      <= code_nxt;
      src       <= src_nxt;
      epc       <= epc_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    code_nxt    = code;
    src_nxt     = src;
    epc_nxt     = epc;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if ((|pend) && !wb_exc_i) begin
          state_nxt = DRAIN;
          code_nxt  = win_code;
          src_nxt   = win;
          cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        cnt_nxt = cnt + 1'b1;
        // Abort on exception or a vanished source beats drain_done; drain_done beats the watchdog.
        if (wb_exc_i || !(|(pend & src))) begin
          state_nxt = IDLE;
        end else if (drain_done_i) begin
          state_nxt = COMMIT;
          epc_nxt   = resume_pc_i;
        end else if (cnt == CW'(DRAIN_MAX)) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end
      end
      COMMIT:  state_nxt = RESUME;
      RESUME:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign irq_req_o       = (state != IDLE);
  assign trap_we_o       = (state == COMMIT);
  assign flush_o         = (state == COMMIT);
  assign trap_cause_o    = trap_we_o ? {1'b1, 27'b0, code} : 32'h0;
  assign trap_epc_o      = trap_we_o ? epc : 32'h0;
  assign drain_timeout_o = timeout_q;
  assign state_o         = state;

endmodule
